// File: rtl/gpu_fill_sched.sv
// Command scheduler for the rectangle-fill engine: buffers normalised, clamped
// fill commands and sequences the engine's start level one rectangle at a time.
module gpu_fill_sched #(
  parameter int unsigned WIDTH_BITS   = 10,
  parameter int unsigned HEIGHT_BITS  = 9,
  parameter int unsigned CHANNEL_BITS = 8,
  parameter int unsigned SCREEN_W     = 640,
  parameter int unsigned SCREEN_H     = 480,
  parameter int unsigned DEPTH        = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid_i,
  output logic                         cmd_ready_o,
  input  logic [WIDTH_BITS-1:0]        cmd_x1_i,
  input  logic [HEIGHT_BITS-1:0]       cmd_y1_i,
  input  logic [WIDTH_BITS-1:0]        cmd_x2_i,
  input  logic [HEIGHT_BITS-1:0]       cmd_y2_i,
  input  logic [CHANNEL_BITS-1:0]      cmd_r_i,
  input  logic [CHANNEL_BITS-1:0]      cmd_g_i,
  input  logic [CHANNEL_BITS-1:0]      cmd_b_i,
  input  logic                         abort_i,
  output logic [WIDTH_BITS-1:0]        fill_x1_o,
  output logic [HEIGHT_BITS-1:0]       fill_y1_o,
  output logic [WIDTH_BITS-1:0]        fill_x2_o,
  output logic [HEIGHT_BITS-1:0]       fill_y2_o,
  output logic [CHANNEL_BITS-1:0]      fill_r_o,
  output logic [CHANNEL_BITS-1:0]      fill_g_o,
  output logic [CHANNEL_BITS-1:0]      fill_b_o,
  output logic                         fill_start_o,
  input  logic                         fill_done_i,
  output logic                         rect_done_o,
  output logic                         idle_o,
  output logic [$clog2(DEPTH+1)-1:0]   cmd_count_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned EW = 2 * WIDTH_BITS + 2 * HEIGHT_BITS + 3 * CHANNEL_BITS;
  localparam logic [WIDTH_BITS-1:0]  XMAX = WIDTH_BITS'(SCREEN_W - 1);
  localparam logic [HEIGHT_BITS-1:0] YMAX = HEIGHT_BITS'(SCREEN_H - 1);

  // FETCH is the cycle after the pop: the head is already in the fill registers
  // but LOAD (start low, coordinates stable) has not been entered yet.
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_RUN, S_RELEASE} state_t;

  state_t                r_state, w_state_nxt;
  logic [EW-1:0]         r_mem [DEPTH];
  logic [PW-1:0]         r_wr, r_rd;
  logic [CW-1:0]         r_count, w_count_nxt;
  logic                  r_start, r_rect_done, r_idle, w_rect_done_nxt;
  logic [EW-1:0]         r_fill, w_entry;
  logic                  w_push, w_pop;
  logic [WIDTH_BITS-1:0]  w_xlo, w_xhi;
  logic [HEIGHT_BITS-1:0] w_ylo, w_yhi;

  always_comb begin
    w_xlo = (cmd_x1_i < cmd_x2_i) ? cmd_x1_i : cmd_x2_i;
    w_xhi = (cmd_x1_i < cmd_x2_i) ? cmd_x2_i : cmd_x1_i;
    w_ylo = (cmd_y1_i < cmd_y2_i) ? cmd_y1_i : cmd_y2_i;
    w_yhi = (cmd_y1_i < cmd_y2_i) ? cmd_y2_i : cmd_y1_i;
    if (w_xlo > XMAX) w_xlo = XMAX;
    if (w_xhi > XMAX) w_xhi = XMAX;
    if (w_ylo > YMAX) w_ylo = YMAX;
    if (w_yhi > YMAX) w_yhi = YMAX;
    w_entry = {w_xlo, w_ylo, w_xhi, w_yhi, cmd_r_i, cmd_g_i, cmd_b_i};
  end

  assign cmd_ready_o = (r_count != CW'(DEPTH));
  assign w_push      = cmd_valid_i && cmd_ready_o && !abort_i;
  assign w_pop       = (r_state == S_IDLE) && (r_count != '0) && !abort_i;
  assign w_count_nxt = abort_i ? '0 : (r_count + CW'(w_push) - CW'(w_pop));

  always_comb begin
    w_state_nxt     = r_state;
    w_rect_done_nxt = 1'b0;
    case (r_state)
      S_IDLE:    if (w_pop) w_state_nxt = S_FETCH;
      S_FETCH:   w_state_nxt = abort_i ? S_IDLE : S_LOAD;
      S_LOAD:    w_state_nxt = abort_i ? S_RELEASE : S_RUN;
      S_RUN: begin
        if (abort_i) begin
          w_state_nxt = S_RELEASE;
        end else if (fill_done_i) begin
          w_state_nxt     = S_RELEASE;
          w_rect_done_nxt = 1'b1;
        end
      end
      S_RELEASE: if (!fill_done_i) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= w_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wr        <= '0;
      r_rd        <= '0;
      r_count     <= '0;
      r_fill      <= '0;
      r_start     <= 1'b0;
      r_rect_done <= 1'b0;
      r_idle      <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_start     <= (w_state_nxt == S_RUN);
      r_rect_done <= w_rect_done_nxt;
      r_idle      <= (w_state_nxt == S_IDLE) && (w_count_nxt == '0);
      if (abort_i) begin
        r_wr <= '0;
        r_rd <= '0;
      end else begin
        if (w_push) r_wr <= r_wr + PW'(1);
        if (w_pop) begin
          r_rd   <= r_rd + PW'(1);
          r_fill <= r_mem[r_rd];
        end
      end
    end
  end

  assign {fill_x1_o, fill_y1_o, fill_x2_o, fill_y2_o, fill_r_o, fill_g_o, fill_b_o} = r_fill;
  assign fill_start_o = r_start;
  assign rect_done_o  = r_rect_done;
  assign idle_o       = r_idle;
  assign cmd_count_o  = r_count;

endmodule

// File: tb/tb_gpu_fill_sched.sv
// Scoreboard bench for gpu_fill_sched: expected rectangles queued at push,
// compared when the engine start level rises; a small engine model answers done.
module tb_gpu_fill_sched;

  localparam int LAT = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid_i = 1'b0;
  logic       cmd_ready_o;
  logic [9:0] cmd_x1_i = '0, cmd_x2_i = '0;
  logic [8:0] cmd_y1_i = '0, cmd_y2_i = '0;
  logic [7:0] cmd_r_i = '0, cmd_g_i = '0, cmd_b_i = '0;
  logic       abort_i = 1'b0;
  logic [9:0] fill_x1_o, fill_x2_o;
  logic [8:0] fill_y1_o, fill_y2_o;
  logic [7:0] fill_r_o, fill_g_o, fill_b_o;
  logic       fill_start_o;
  logic       fill_done_i = 1'b0;
  logic       rect_done_o;
  logic       idle_o;
  logic [2:0] cmd_count_o;

  gpu_fill_sched #(
    .WIDTH_BITS(10), .HEIGHT_BITS(9), .CHANNEL_BITS(8),
    .SCREEN_W(640), .SCREEN_H(480), .DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_x1_i(cmd_x1_i), .cmd_y1_i(cmd_y1_i), .cmd_x2_i(cmd_x2_i), .cmd_y2_i(cmd_y2_i),
    .cmd_r_i(cmd_r_i), .cmd_g_i(cmd_g_i), .cmd_b_i(cmd_b_i),
    .abort_i(abort_i),
    .fill_x1_o(fill_x1_o), .fill_y1_o(fill_y1_o), .fill_x2_o(fill_x2_o), .fill_y2_o(fill_y2_o),
    .fill_r_o(fill_r_o), .fill_g_o(fill_g_o), .fill_b_o(fill_b_o),
    .fill_start_o(fill_start_o), .fill_done_i(fill_done_i),
    .rect_done_o(rect_done_o), .idle_o(idle_o), .cmd_count_o(cmd_count_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;
  int eng_mode = 0;  // 0 auto, 1 done held low, 2 done held high
  logic [61:0] sb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [61:0] model(input int x1, input int y1, input int x2, input int y2,
                                        input int r, input int g, input int b);
    int xl, xh, yl, yh;
    xl = (x1 <= x2) ? x1 : x2;  xh = (x1 <= x2) ? x2 : x1;
    yl = (y1 <= y2) ? y1 : y2;  yh = (y1 <= y2) ? y2 : y1;
    if (xl > 639) xl = 639;  if (xh > 639) xh = 639;
    if (yl > 479) yl = 479;  if (yh > 479) yh = 479;
    return {10'(xl), 9'(yl), 10'(xh), 9'(yh), 8'(r), 8'(g), 8'(b)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int x1, input int y1, input int x2, input int y2,
                       input int r, input int g, input int b);
    cmd_x1_i = 10'(x1); cmd_y1_i = 9'(y1); cmd_x2_i = 10'(x2); cmd_y2_i = 9'(y2);
    cmd_r_i = 8'(r); cmd_g_i = 8'(g); cmd_b_i = 8'(b);
  endtask

  task automatic push(input int x1, input int y1, input int x2, input int y2,
                      input int r, input int g, input int b);
    int t = 0;
    drive(x1, y1, x2, y2, r, g, b);
    cmd_valid_i = 1'b1;
    while (!cmd_ready_o && t < 500) begin
      tick();
      t++;
    end
    if (t >= 500) begin
      check("push_timeout", 0, 1);
    end else begin
      @(posedge clk);
      sb.push_back(model(x1, y1, x2, y2, r, g, b));
      #1;
    end
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int t = 0;
    while (!idle_o && t < limit) begin
      tick();
      t++;
    end
    check(tag, idle_o, 1);
  endtask

  // Engine model: raises done LAT cycles into the start level, drops it once start falls.
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      if (eng_mode == 1) begin
        fill_done_i = 1'b0; cnt = 0;
      end else if (eng_mode == 2) begin
        fill_done_i = 1'b1; cnt = 0;
      end else if (fill_done_i) begin
        if (!fill_start_o) begin fill_done_i = 1'b0; cnt = 0; end
      end else if (fill_start_o) begin
        cnt++;
        if (cnt >= LAT) fill_done_i = 1'b1;
      end
    end
  end

  // Output monitor: scoreboard compare on start rise, start-low gap, done pulse placement.
  initial begin
    logic prev_start = 1'b0;
    bit   have_prev  = 1'b0;
    int   low_cnt    = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_start = 1'b0; have_prev = 1'b0; low_cnt = 0;
      end else begin
        if (fill_start_o && !prev_start) begin
          if (sb.size() == 0) begin
            check("sb_unexpected_start", 1, 0);
          end else begin
            check("rect_fields",
                  {fill_x1_o, fill_y1_o, fill_x2_o, fill_y2_o, fill_r_o, fill_g_o, fill_b_o},
                  sb.pop_front());
          end
          if (have_prev) check("start_gap_ge2", 64'(low_cnt >= 2), 1);
          have_prev = 1'b1;
          low_cnt   = 0;
        end
        if (!fill_start_o) low_cnt++;
        if (rect_done_o) begin
          n_done++;
          check("done_on_start_fall", {prev_start, fill_start_o}, 2'b10);
        end
        prev_start = fill_start_o;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, saved;

    // Reset
    rst = 1'b1;
    tick(); tick();
    check("rst_idle", idle_o, 1);
    check("rst_ready", cmd_ready_o, 1);
    check("rst_start", fill_start_o, 0);
    check("rst_count", cmd_count_o, 0);
    check("rst_rect_done", rect_done_o, 0);
    check("rst_fill", {fill_x1_o, fill_y2_o, fill_r_o}, 0);
    rst = 1'b0;
    tick();

    // Single command with latency
    push(10, 5, 3, 20, 8'hFF, 8'h00, 8'h80);   // edge N
    check("single_count_n", cmd_count_o, 1);
    check("single_idle_n", idle_o, 0);
    tick();                                     // N+1
    check("single_count_n1", cmd_count_o, 0);
    tick();                                     // N+2
    check("single_coords_n2", {fill_x1_o, fill_x2_o, fill_y1_o, fill_y2_o},
          {10'd3, 10'd10, 9'd5, 9'd20});
    check("single_start_n2", fill_start_o, 0);
    tick();                                     // N+3
    check("single_start_n3", fill_start_o, 1);
    t = 0;
    while (!rect_done_o && t < 200) begin tick(); t++; end
    check("single_rect_done", rect_done_o, 1);
    check("single_start_drop", fill_start_o, 0);
    tick();
    check("single_done_pulse1", rect_done_o, 0);
    wait_idle("single_idle", 50);
    check("single_n_done", n_done, 1);

    // Clamping, degenerate and both-out-of-range
    push(100, 50, 1000, 500, 1, 2, 3);
    tick(); tick();
    check("clamp_x2", fill_x2_o, 639);
    check("clamp_y2", fill_y2_o, 479);
    wait_idle("clamp_idle", 300);
    push(7, 9, 7, 9, 8'h11, 8'h22, 8'h33);
    wait_idle("degen_idle", 300);
    push(1023, 511, 700, 490, 8'hAA, 8'hBB, 8'hCC);
    wait_idle("both_clamp_idle", 300);
    check("clamp_n_done", n_done, 4);

    // Full FIFO with engine stalled
    eng_mode = 1;
    for (int i = 0; i < 5; i++) push(i * 50, i * 30, i * 50 + 20, i * 30 + 10, i, i + 1, i + 2);
    tick(); tick();
    check("full_count", cmd_count_o, 4);
    check("full_ready", cmd_ready_o, 0);
    check("full_start", fill_start_o, 1);
    eng_mode = 0;
    push(600, 400, 630, 470, 8'h5A, 8'hA5, 8'h3C);
    wait_idle("full_idle", 2000);
    check("full_n_done", n_done, 10);
    check("full_sb_drained", sb.size(), 0);

    // Abort mid-RUN with 3 queued; simultaneous push is dropped
    eng_mode = 1;
    for (int i = 0; i < 4; i++) push(20 + i, 30, 40, 60 + i, 8'h10, 8'h20, 8'h30 + i);
    check("abort_pre_count", cmd_count_o, 3);
    check("abort_pre_start", fill_start_o, 1);
    saved = n_done;
    abort_i = 1'b1;
    cmd_valid_i = 1'b1;
    drive(1, 1, 2, 2, 3, 3, 3);
    tick();
    abort_i = 1'b0;
    cmd_valid_i = 1'b0;
    sb.delete();
    check("abort_count", cmd_count_o, 0);
    check("abort_start", fill_start_o, 0);
    check("abort_no_done", rect_done_o, 0);
    eng_mode = 0;
    wait_idle("abort_idle", 20);
    repeat (5) tick();
    check("abort_n_done", n_done, saved);
    check("abort_stays_idle", {idle_o, fill_start_o, cmd_count_o}, {1'b1, 1'b0, 3'd0});

    // Reset mid-RUN, done stuck high afterwards
    push(5, 5, 15, 15, 1, 1, 1);
    t = 0;
    while (!fill_start_o && t < 20) begin tick(); t++; end
    check("rrun_started", fill_start_o, 1);
    saved = n_done;
    rst = 1'b1;
    eng_mode = 2;
    tick(); tick();
    rst = 1'b0;
    sb.delete();
    repeat (4) tick();
    check("rrun_start", fill_start_o, 0);
    check("rrun_rect_done", rect_done_o, 0);
    check("rrun_idle", idle_o, 1);
    check("rrun_count_ready", {cmd_count_o, cmd_ready_o}, {3'd0, 1'b1});
    check("rrun_fill", {fill_x1_o, fill_y1_o, fill_x2_o, fill_y2_o, fill_r_o, fill_g_o, fill_b_o}, 0);
    check("rrun_n_done", n_done, saved);
    eng_mode = 0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gpu_fill_sched.md
Name: gpu_fill_sched

Overview:
- Command scheduler for the rectangle-fill engine.
- Accepts fill-rect commands from the command decoder through a valid/ready port and buffers them in a small FIFO.
- Normalises and clamps the coordinates of each command, then sequences the fill engine one command at a time.
- Drives the engine's start level: low for one cycle, high until done, then low until done clears. Reports completions and idle status to the top-level GPU control.

Parameters:
- WIDTH_BITS, 10, x coordinate width.
- HEIGHT_BITS, 9, y coordinate width.
- CHANNEL_BITS, 8, colour channel width.
- SCREEN_W, 640, screen width in pixels; x clamp limit is SCREEN_W-1.
- SCREEN_H, 480, screen height in pixels; y clamp limit is SCREEN_H-1.
- DEPTH, 4, command FIFO entries (power of two, minimum 2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid_i  in  1  command offered.
- cmd_ready_o  out  1  FIFO can accept.
- cmd_x1_i  in  WIDTH_BITS  corner A x.
- cmd_y1_i  in  HEIGHT_BITS  corner A y.
- cmd_x2_i  in  WIDTH_BITS  corner B x.
- cmd_y2_i  in  HEIGHT_BITS  corner B y.
- cmd_r_i, cmd_g_i, cmd_b_i  in  CHANNEL_BITS each  fill colour.
- abort_i  in  1  flush FIFO and stop the engine.
- fill_x1_o  out  WIDTH_BITS  engine x1.
- fill_y1_o  out  HEIGHT_BITS  engine y1.
- fill_x2_o  out  WIDTH_BITS  engine x2.
- fill_y2_o  out  HEIGHT_BITS  engine y2.
- fill_r_o, fill_g_o, fill_b_o  out  CHANNEL_BITS each  engine colour.
- fill_start_o  out  1  engine start level.
- fill_done_i  in  1  engine done.
- rect_done_o  out  1  one-cycle pulse per completed rectangle.
- idle_o  out  1  FIFO empty and state IDLE.
- cmd_count_o  out  $clog2(DEPTH+1)  FIFO occupancy.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state IDLE, FIFO empty, count 0.
  - fill_start_o=0, rect_done_o=0, all fill_*_o=0.
  - cmd_ready_o=1, idle_o=1.
  - Reset overrides all other inputs, including mid-RUN.
- Push:
  - cmd_ready_o = (count != DEPTH).
  - A push occurs when cmd_valid_i && cmd_ready_o.
  - Normalisation is applied at push time: x_lo=min(x1,x2), x_hi=max(x1,x2); same for y.
  - Clamping follows: any value > SCREEN_W-1 (x) or > SCREEN_H-1 (y) is stored as that limit.
- Pop: only in IDLE when count != 0. A simultaneous push and pop leaves count unchanged. Push while full is refused via ready; no overflow path.
- States, all outputs registered:
  - IDLE: if count != 0, pop the head into the fill_*_o registers and go to LOAD. fill_start_o=0.
  - LOAD: exactly 1 cycle with fill_start_o=0 and coordinates stable. This guarantees a rising edge at the engine. Go to RUN.
  - RUN: fill_start_o=1; coordinates and colour stay frozen. When fill_done_i=1, go to RELEASE and assert rect_done_o for one cycle on that transition.
  - RELEASE: fill_start_o=0. Wait for fill_done_i=0, then go to IDLE. Minimum 1 cycle in RELEASE.
- Latency: with an empty FIFO in IDLE, a command pushed at edge N is popped at N+1, LOAD is entered at N+2, and fill_start_o rises at N+3.
- Back-to-back commands: start is low for at least 2 cycles between rectangles (RELEASE plus LOAD).
- fill_done_i high while in IDLE or LOAD is ignored.
- abort_i (lower priority than rst), at the next edge:
  - FIFO is cleared and count=0.
  - If in LOAD or RUN, go to RELEASE with fill_start_o=0 and no rect_done_o pulse.
  - A push in the same cycle as abort is discarded.
- idle_o = (state==IDLE) && (count==0), registered.
- Degenerate rectangles: x1==x2 and/or y1==y2 are legal and go through the full sequence.

Test Plan:
- Reset then idle: hold rst 2 cycles → idle_o=1, cmd_ready_o=1, fill_start_o=0, cmd_count_o=0.
- Single command: push (x1=10,y1=5,x2=3,y2=20,rgb=FF/00/80) at edge N → at N+2 fill_x1_o=3, fill_x2_o=10, fill_y1_o=5, fill_y2_o=20. fill_start_o=1 at N+3. Model asserts done after 50 cycles → rect_done_o pulses once, start drops, idle_o=1 after done clears.
- Clamping: push x2=1000, y2=500 → fill_x2_o=639, fill_y2_o=479.
- Full FIFO: engine done held low, push 6 commands → first popped into RUN, then 4 buffered. cmd_ready_o=0 with count=4; the 6th waits until the first completes. Rectangles are then issued in push order with a start-low gap of at least 2 cycles.
- Abort mid-RUN with 3 queued → next edge: count=0, fill_start_o=0, no rect_done_o pulse, state IDLE once done low.
- Reset mid-RUN, with fill_done_i stuck high afterwards → all outputs at reset values. No spurious rect_done_o.
